mips32_if_queue: RTL and testbench

Instruction-fetch stage with prefetch queue, directly upstream of the mips32_RISCV decode stage. It drives word-addressed requests into the synchronous instruction memory and buffers returned words with their PC in a small FIFO. It presents the words to decode over a valid/ready handshake. A redirect from the execute stage (branch or jump taken) flushes all buffered and in-flight fetches and restarts fetch at the new PC.

---
 rtl/mips32_if_queue.sv | 104 ++++++++++
 tb/tb_mips32_if_queue.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_if_queue.sv
// Instruction-fetch stage with prefetch FIFO feeding decode over valid/ready.
// Optional macro IFQ_BYPASS_EN: an empty queue forwards the returning word combinationally.
module mips32_if_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc
);

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] inf_pc;
    logic              inf_v;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [31:0]       mem_instr [DEPTH];
    logic [ADDR_W-1:0] mem_pc    [DEPTH];

    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              resp;
    logic              head_valid;
    logic              push;
    logic              pop;

    // Credit counts the in-flight slot so a returning word always has room.
    assign occupancy  = {1'b0, count} + (CNT_W + 1)'(inf_v);
    assign issue      = rst_n & ~redirect_valid & (occupancy < DEPTH_C);
    assign imem_req   = issue;
    assign imem_addr  = fpc;
    assign resp       = inf_v & ~redirect_valid;
    assign head_valid = (count != '0);

    // Handshake: a word transfers on a cycle where id_valid && id_ready; the
    // producer holds id_instr/id_pc stable until then, except a redirect
    // cycle, which discards everything and never counts as a transfer.
    assign pop = head_valid & id_ready & ~redirect_valid;

`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass   = resp & ~head_valid;
    assign id_valid = head_valid | bypass;
    assign id_instr = bypass ? imem_rdata : mem_instr[rd_ptr];
    assign id_pc    = bypass ? inf_pc     : mem_pc[rd_ptr];
    assign push     = resp & ~(bypass & id_ready);
`else
    assign id_valid = head_valid;
    assign id_instr = mem_instr[rd_ptr];
    assign id_pc    = mem_pc[rd_ptr];
    assign push     = resp;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc    <= RESET_PC;
            inf_pc <= RESET_PC;
            inf_v  <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            // Flush: drop queued words and the response arriving this cycle.
            fpc    <= redirect_pc;
            inf_v  <= 1'b0;
            count  <= '0;
            wr_ptr <= rd_ptr;
        end else begin
            inf_v <= issue;
            if (issue) begin
                inf_pc <= fpc;
                fpc    <= fpc + ADDR_W'(1);
            end
            if (push) begin
                mem_instr[wr_ptr] <= imem_rdata;
                mem_pc[wr_ptr]    <= inf_pc;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_mips32_if_queue.sv
// Scoreboard bench for mips32_if_queue: directed scenarios push expected PCs,
// a negedge monitor pops and compares on every accepted instruction.
module tb_mips32_if_queue;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int M      = 6;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata = 32'hdead_beef;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              id_valid;
  logic              id_ready = 1'b0;
  logic [31:0]       id_instr;
  logic [ADDR_W-1:0] id_pc;

  int tests   = 0;
  int fails   = 0;
  int pop_cnt = 0;
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] mon_exp;

  mips32_if_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC('0)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
    return 32'(a) * 32'h0101_0101;
  endfunction

  // memory: data one cycle after the request, garbage otherwise
  always @(posedge clk) imem_rdata <= imem_req ? word_of(imem_addr) : 32'hdead_beef;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic cyc(input logic rn, input logic rdy, input logic rv, input logic [ADDR_W-1:0] rpc);
    @(posedge clk);
    #1;
    rst_n          = rn;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic push_range(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ADDR_W'(base + i));
  endtask

  task automatic finish_test(input string name);
    cyc(1'b1, 1'b0, 1'b0, '0);
    sample();
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready && !redirect_valid) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got pc %0d expected no instruction", id_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_pc", 32'(id_pc), 32'(mon_exp));
        check("pop_instr", id_instr, word_of(mon_exp));
      end
    end
  end

  initial begin
    int start;

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, '0);
      sample();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_pc", 32'(id_pc), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
    end
    cyc(1'b1, 1'b0, 1'b0, '0);
    sample();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);

    // streaming: 8 instructions, one per cycle from cycle LAT
    do_reset();
    start = pop_cnt;
    push_range(0, 8);
    for (int c = 0; c < LAT + 8; c++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      if (c == 0 || c == 1) begin
        sample();
        check("stream_early_valid", 32'(id_valid), 32'(c >= LAT));
      end
    end
    finish_test("stream_drained");
    check("stream_pops", 32'(pop_cnt - start), 32'd8);

    // backpressure: exactly 4 requests, then resume at 4 once drained
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc(1'b1, 1'b0, 1'b0, '0);
      sample();
      check("bp_req", 32'(imem_req), 32'(c < 4));
      if (c < 4) check("bp_addr", 32'(imem_addr), 32'(c));
    end
    check("bp_full_valid", 32'(id_valid), 32'd1);
    start = pop_cnt;
    push_range(0, 8);
    for (int c = 8; c < 16; c++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      if (c == 8) begin
        sample();
        check("bp_pop_not_credited", 32'(imem_req), 32'd0);
      end
      if (c == 9) begin
        sample();
        check("bp_resume_req", 32'(imem_req), 32'd1);
        check("bp_resume_addr", 32'(imem_addr), 32'd4);
      end
    end
    finish_test("bp_drained");
    check("bp_pops", 32'(pop_cnt - start), 32'd8);

    // redirect mid-stream at fpc=5: 2 queued, 1 in flight, all dropped
    do_reset();
    push_range(0, 2);
    for (int c = 0; c < LAT + 2; c++) cyc(1'b1, 1'b1, 1'b0, '0);
    for (int c = LAT + 2; c < 5; c++) cyc(1'b1, 1'b0, 1'b0, '0);
    sample();
    check("rd_pre_addr", 32'(imem_addr), 32'd4);
    cyc(1'b1, 1'b0, 1'b1, ADDR_W'(40));
    sample();
    check("rd_cycle_req", 32'(imem_req), 32'd0);
    push_range(40, M);
    for (int c = 6; c <= 5 + LAT + M; c++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      if (c == 6) begin
        sample();
        check("rd_next_req", 32'(imem_req), 32'd1);
        check("rd_next_addr", 32'(imem_addr), 32'd40);
        check("rd_flushed_valid", 32'(id_valid), 32'd0);
      end
    end
    finish_test("rd_drained");

    // redirect with full queue and simultaneous pop
    do_reset();
    for (int c = 0; c < 6; c++) cyc(1'b1, 1'b0, 1'b0, '0);
    sample();
    check("full_req", 32'(imem_req), 32'd0);
    start = pop_cnt;
    cyc(1'b1, 1'b1, 1'b1, ADDR_W'(100));
    sample();
    check("full_rd_req", 32'(imem_req), 32'd0);
    check("full_rd_valid", 32'(id_valid), 32'd1);
    push_range(100, M);
    for (int c = 7; c <= 6 + LAT + M; c++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      if (c == 7) begin
        sample();
        check("full_after_valid", 32'(id_valid), 32'd0);
        check("full_after_req", 32'(imem_req), 32'd1);
        check("full_after_addr", 32'(imem_addr), 32'd100);
      end
    end
    finish_test("full_drained");
    check("full_pops", 32'(pop_cnt - start), 32'(M));

    // wrap: redirect to 1022 on an empty queue
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, ADDR_W'(1022));
    sample();
    check("wrap_rd_req", 32'(imem_req), 32'd0);
    push_range(1022, 4);
    for (int c = 1; c <= LAT + 4; c++) begin
      cyc(1'b1, 1'b1, 1'b0, '0);
      if (c <= 4) begin
        sample();
        check("wrap_req", 32'(imem_req), 32'd1);
        check("wrap_addr", 32'(imem_addr), 32'((1021 + c) % 1024));
      end
    end
    finish_test("wrap_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
